// File: rtl/xalu_issue_ctrl_pkg.sv
// Shared definitions for the mult/div issue controller: instruction kinds,
// xalu_op bit layout and op encodings, and the FSM state type.
package xalu_issue_ctrl_pkg;

    localparam logic [2:0] KIND_NONE  = 3'd0;
    localparam logic [2:0] KIND_MULT  = 3'd1;
    localparam logic [2:0] KIND_MULTU = 3'd2;
    localparam logic [2:0] KIND_DIV   = 3'd3;
    localparam logic [2:0] KIND_DIVU  = 3'd4;
    localparam logic [2:0] KIND_MFHI  = 3'd5;
    localparam logic [2:0] KIND_MFLO  = 3'd6;
    localparam logic [2:0] KIND_MTX   = 3'd7;

    localparam int OP_UNSIGNED_BIT = 0;
    localparam int OP_MULT_BIT     = 1;
    localparam int OP_DIV_BIT      = 2;
    localparam int OP_RSVD_BIT     = 3;

    localparam logic [3:0] OP_NONE  = 4'b0000;
    localparam logic [3:0] OP_MULT  = 4'b0010;
    localparam logic [3:0] OP_MULTU = 4'b0011;
    localparam logic [3:0] OP_DIV   = 4'b0100;
    localparam logic [3:0] OP_DIVU  = 4'b0101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    function automatic logic [3:0] kind_to_op(input logic [2:0] kind);
        logic [3:0] op;
        op = OP_NONE;
        op[OP_MULT_BIT]     = (kind == KIND_MULT)  || (kind == KIND_MULTU);
        op[OP_DIV_BIT]      = (kind == KIND_DIV)   || (kind == KIND_DIVU);
        op[OP_UNSIGNED_BIT] = (kind == KIND_MULTU) || (kind == KIND_DIVU);
        op[OP_RSVD_BIT]     = 1'b0;
        return op;
    endfunction

endpackage

// File: rtl/xalu_issue_ctrl.sv
// EX-stage issue controller for the multiply/divide unit: issues ops, writes
// HI/LO, stalls only HI/LO-class instructions while the unit is busy.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | unit free; HI/LO-class instructions are handled directly
//   ST_WAIT | op issued, unit busy; HI/LO-class instructions are stalled
module xalu_issue_ctrl
    import xalu_issue_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 63,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic [2:0]  ex_kind,
    input  logic        ex_to_lo,
    input  logic        ex_flush,
    input  logic [31:0] ex_rt_data,
    input  logic [31:0] ex_rs_data,
    input  logic        xalu_busy,
    output logic [3:0]  xalu_op,
    output logic        xalu_hi_we,
    output logic        xalu_lo_we,
    output logic [31:0] xalu_wdata,
    output logic        xalu_out_sel,
    output logic        stall,
    output logic        div0,
    output logic        wd_err
);

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_WAIT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wd_cnt;
    logic             wd_err_q;
    logic             wd_fire;
    logic             hilo, muldiv, is_div, div_zero;

    assign hilo     = ex_valid & ~ex_flush & (ex_kind != KIND_NONE);
    assign muldiv   = hilo & (ex_kind >= KIND_MULT) & (ex_kind <= KIND_DIVU);
    assign is_div   = (ex_kind == KIND_DIV) || (ex_kind == KIND_DIVU);
    assign div_zero = is_div & (ex_rt_data == 32'd0);
    // wd_cnt holds the number of completed WAIT cycles, so 0 marks the first one
    assign wd_fire  = (state == ST_WAIT) && (wd_cnt == WD_LAST);
    assign wd_err   = wd_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            wd_cnt   <= '0;
            wd_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_WAIT && state_nxt == ST_WAIT)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
            if (wd_fire)
                wd_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        xalu_op      = OP_NONE;
        xalu_hi_we   = 1'b0;
        xalu_lo_we   = 1'b0;
        xalu_wdata   = 32'd0;
        xalu_out_sel = 1'b0;
        stall        = 1'b0;
        div0         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (muldiv) begin
                    if (div_zero) begin
                        div0 = 1'b1;
                    end else begin
                        xalu_op   = kind_to_op(ex_kind);
                        state_nxt = ST_WAIT;
                    end
                end
                if (hilo && ex_kind == KIND_MFLO)
                    xalu_out_sel = 1'b1;
                if (hilo && ex_kind == KIND_MTX) begin
                    xalu_wdata = ex_rs_data;
                    xalu_lo_we = ex_to_lo;
                    xalu_hi_we = ~ex_to_lo;
                end
            end
            ST_WAIT: begin
                stall = hilo;
                // BUSY is ignored in the first WAIT cycle since it may lag the issue
                if (wd_fire || (wd_cnt != '0 && !xalu_busy))
                    state_nxt = ST_IDLE;
            end
        endcase
        // reset must drop stall and strobes immediately, not at the next edge
        if (!reset_n) begin
            state_nxt    = ST_IDLE;
            xalu_op      = OP_NONE;
            xalu_hi_we   = 1'b0;
            xalu_lo_we   = 1'b0;
            xalu_wdata   = 32'd0;
            xalu_out_sel = 1'b0;
            stall        = 1'b0;
            div0         = 1'b0;
        end
    end

endmodule

// File: tb/tb_xalu_issue_ctrl.sv
// Testbench for xalu_issue_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_xalu_issue_ctrl;

    localparam int MAX_WAIT = 63;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid, ex_to_lo, ex_flush, xalu_busy;
    logic [2:0]  ex_kind;
    logic [31:0] ex_rt_data, ex_rs_data;
    logic [3:0]  xalu_op;
    logic        xalu_hi_we, xalu_lo_we, xalu_out_sel, stall, div0, wd_err;
    logic [31:0] xalu_wdata;

    int vectors = 0;
    int miscompares = 0;

    // model state: are we waiting on the unit, how many WAIT cycles elapsed, sticky error
    bit m_waiting = 0;
    int m_wait_cycles = 0;
    bit m_wd = 0;

    xalu_issue_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_kind(ex_kind),
        .ex_to_lo(ex_to_lo), .ex_flush(ex_flush), .ex_rt_data(ex_rt_data),
        .ex_rs_data(ex_rs_data), .xalu_busy(xalu_busy), .xalu_op(xalu_op),
        .xalu_hi_we(xalu_hi_we), .xalu_lo_we(xalu_lo_we), .xalu_wdata(xalu_wdata),
        .xalu_out_sel(xalu_out_sel), .stall(stall), .div0(div0), .wd_err(wd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit          live, mdiv, dz;
        logic [3:0]  e_op;
        logic        e_stall, e_div0, e_hi, e_lo, e_sel, sel_known;
        live = reset_n && ex_valid && !ex_flush && ex_kind != 3'd0;
        mdiv = live && ex_kind >= 3'd1 && ex_kind <= 3'd4;
        dz   = (ex_kind == 3'd3 || ex_kind == 3'd4) && ex_rt_data == 32'd0;
        e_op = 4'b0000; e_stall = 0; e_div0 = 0; e_hi = 0; e_lo = 0; e_sel = 0;
        sel_known = 0;
        if (!reset_n) begin
            m_waiting = 0; m_wait_cycles = 0; m_wd = 0;
            sel_known = 1;
        end else if (m_waiting) begin
            e_stall = live;
            sel_known = live;
        end else begin
            if (mdiv && dz) e_div0 = 1;
            else if (mdiv) begin
                case (ex_kind)
                    3'd1: e_op = 4'b0010;
                    3'd2: e_op = 4'b0011;
                    3'd3: e_op = 4'b0100;
                    default: e_op = 4'b0101;
                endcase
            end
            if (live && (ex_kind == 3'd5 || ex_kind == 3'd6)) begin
                sel_known = 1;
                e_sel = (ex_kind == 3'd6);
            end
            if (live && ex_kind == 3'd7) begin
                e_lo = ex_to_lo;
                e_hi = !ex_to_lo;
            end
        end
        chk("op", xalu_op, e_op);
        chk("stall", stall, e_stall);
        chk("div0", div0, e_div0);
        chk("hi_we", xalu_hi_we, e_hi);
        chk("lo_we", xalu_lo_we, e_lo);
        chk("wd_err", wd_err, m_wd);
        if (sel_known) chk("out_sel", xalu_out_sel, e_sel);
        if (e_hi || e_lo) chk("wdata", xalu_wdata, ex_rs_data);
        // advance the model to the next rising edge
        if (reset_n) begin
            if (m_waiting) begin
                m_wait_cycles++;
                if (m_wait_cycles == MAX_WAIT) begin
                    m_wd = 1; m_waiting = 0;
                end else if (m_wait_cycles >= 2 && !xalu_busy) begin
                    m_waiting = 0;
                end
            end else if (mdiv && !dz) begin
                m_waiting = 1;
                m_wait_cycles = 0;
            end
        end
    end

    task automatic cyc(input logic v, input logic [2:0] k, input logic tl, input logic fl,
                       input logic [31:0] rt, input logic [31:0] rs, input logic b);
        @(posedge clk);
        #1;
        ex_valid = v; ex_kind = k; ex_to_lo = tl; ex_flush = fl;
        ex_rt_data = rt; ex_rs_data = rs; xalu_busy = b;
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset_n = 0;
        ex_valid = 0; ex_kind = 0; ex_to_lo = 0; ex_flush = 0;
        ex_rt_data = 0; ex_rs_data = 0; xalu_busy = 0;
        #3;
        chk("rst_stall", stall, 0);
        chk("rst_op", xalu_op, 0);
        chk("rst_wd", wd_err, 0);
        #20;
        @(posedge clk); #2 reset_n = 1;

        // MULT then independent ADD, then MFLO held behind BUSY
        cyc(1, 3'd1, 0, 0, 32'd7, 32'hFFFF_FFFD, 0);
        chk("mult_op", xalu_op, 4'b0010);
        cyc(1, 3'd0, 0, 0, 0, 0, 1);
        chk("add_nostall", stall, 0);
        chk("wait_no_reissue", xalu_op, 0);
        cyc(1, 3'd6, 0, 0, 0, 0, 1);
        chk("mflo_stall", stall, 1);
        cyc(1, 3'd6, 0, 0, 0, 0, 0);
        chk("mflo_stall_busyfall", stall, 1);
        cyc(1, 3'd6, 0, 0, 0, 0, 0);
        chk("mflo_release", stall, 0);
        chk("mflo_sel", xalu_out_sel, 1);

        // DIVU by zero
        cyc(1, 3'd4, 0, 0, 32'd0, 32'd9, 0);
        chk("divu0_div0", div0, 1);
        chk("divu0_op", xalu_op, 0);
        cyc(1, 3'd5, 0, 0, 0, 0, 0);
        chk("mfhi_after_div0", stall, 0);
        chk("div0_pulse", div0, 0);

        // MTLO in IDLE
        cyc(1, 3'd7, 1, 0, 0, 32'hDEAD_BEEF, 0);
        chk("mtlo_lo_we", xalu_lo_we, 1);
        chk("mtlo_hi_we", xalu_hi_we, 0);
        chk("mtlo_wdata", xalu_wdata, 32'hDEAD_BEEF);

        // DIV, stalled MTLO, flushed MFHI during WAIT
        cyc(1, 3'd3, 0, 0, 32'd5, 0, 1);
        chk("div_op", xalu_op, 4'b0100);
        cyc(1, 3'd7, 1, 0, 0, 32'hDEAD_BEEF, 1);
        chk("mtlo_wait_stall", stall, 1);
        chk("mtlo_wait_we", xalu_lo_we, 0);
        cyc(1, 3'd5, 0, 1, 0, 0, 1);
        chk("flush_nostall", stall, 0);
        chk("flush_no_op", xalu_op, 0);
        cyc(0, 3'd0, 0, 0, 0, 0, 0);
        chk("wait_busyfall_op", xalu_op, 0);
        cyc(1, 3'd7, 1, 0, 0, 32'h1234_5678, 0);
        chk("mtlo_after_wait", xalu_lo_we, 1);

        // watchdog: BUSY stuck high
        cyc(1, 3'd2, 0, 0, 32'd1, 0, 1);
        chk("multu_op", xalu_op, 4'b0011);
        for (int i = 0; i < MAX_WAIT; i++) cyc(1, 3'd5, 0, 0, 0, 0, 1);
        chk("wd_last_wait_stall", stall, 1);
        chk("wd_not_yet", wd_err, 0);
        cyc(1, 3'd5, 0, 0, 0, 0, 1);
        chk("wd_fired", wd_err, 1);
        chk("wd_release", stall, 0);
        for (int i = 0; i < 4; i++) cyc(0, 3'd0, 0, 0, 0, 0, 0);
        chk("wd_sticky", wd_err, 1);

        // async reset in WAIT with a stalled MULT
        cyc(1, 3'd1, 0, 0, 32'd3, 0, 1);
        chk("mult2_op", xalu_op, 4'b0010);
        cyc(1, 3'd1, 0, 0, 32'd3, 0, 1);
        chk("mult_pending_stall", stall, 1);
        #2 reset_n = 0;
        #1;
        chk("async_stall", stall, 0);
        chk("async_op", xalu_op, 0);
        chk("async_wd", wd_err, 0);
        @(negedge clk);
        @(posedge clk); #1 reset_n = 1;
        @(negedge clk); #1;
        chk("mult_after_reset", xalu_op, 4'b0010);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 85, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 9) == 0,
                ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom), 32'($urandom),
                $urandom_range(0, 9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
